// File: rtl/nfc_rx_byte_packer_pkg.sv
// rtl/nfc_rx_byte_packer_pkg.sv - shared definitions for the NAND read-data byte packer
// Purpose: FIFO entry layout, byte-keep constants and a keep-to-byte-count helper.
// Ports: none (package).
package nfc_rx_pkg;

    localparam int ENTRY_W        = 9;
    localparam int ENTRY_LAST_BIT = 8;
    localparam int HALF_W         = 2 * ENTRY_W;

    localparam logic [3:0] KEEP_1B = 4'b0001;
    localparam logic [3:0] KEEP_2B = 4'b0011;
    localparam logic [3:0] KEEP_3B = 4'b0111;
    localparam logic [3:0] KEEP_4B = 4'b1111;

    // One 9-bit FIFO entry; bLast sits at ENTRY_LAST_BIT.
    typedef struct packed {
        logic       bLast;
        logic [7:0] data;
    } fifoEntryT;

    // Keep masks are always contiguous from lane 0, so this is a plain popcount.
    function automatic logic [2:0] keepBytes(input logic [3:0] keep);
        keepBytes = 3'(keep[0]) + 3'(keep[1]) + 3'(keep[2]) + 3'(keep[3]);
    endfunction

endpackage

// File: rtl/nfc_rx_byte_packer_if.sv
// rtl/nfc_rx_byte_packer_if.sv - FIFO-pop and DMA-word signals of the byte packer
// Purpose: bundles the FIFO read side and the packed-word valid/ready side.
// Ports (slave = packer view):
//   iFifoData  in  18  FIFO pop data, [17:9] earlier entry, [8:0] later entry
//   iFifoEmpty in  1   FIFO empty flag
//   oFifoPop   out 1   FIFO pop strobe (data valid the following cycle)
//   oData      out 32  packed word, earliest byte in lane 0
//   oKeep      out 4   byte valid mask
//   oLast      out 1   word holds the final byte of the transfer
//   oValid     out 1   word valid
//   iReady     in  1   downstream accept
//   oByteCount out COUNT_WIDTH bytes accepted in the current transfer
interface nfc_rx_byte_packer_if
    import nfc_rx_pkg::*;
    #(parameter int COUNT_WIDTH = 16) ();

    logic [HALF_W-1:0]      iFifoData;
    logic                   iFifoEmpty;
    logic                   oFifoPop;
    logic [31:0]            oData;
    logic [3:0]             oKeep;
    logic                   oLast;
    logic                   oValid;
    logic                   iReady;
    logic [COUNT_WIDTH-1:0] oByteCount;

    modport slave (
        input  iFifoData, iFifoEmpty, iReady,
        output oFifoPop, oData, oKeep, oLast, oValid, oByteCount
    );

    modport master (
        output iFifoData, iFifoEmpty, iReady,
        input  oFifoPop, oData, oKeep, oLast, oValid, oByteCount
    );

endinterface

// File: rtl/nfc_rx_byte_packer.sv
// rtl/nfc_rx_byte_packer.sv - packs 18-bit NAND FIFO halfwords into 32-bit DMA words
// Purpose: pops two {bLast, byte} entries at a time, packs bytes into 32-bit
//   words with a keep mask, flushes a partial word on bLast and restarts the
//   next transfer in lane 0. Pad entries after bLast are dropped.
// Ports:
//   iClock  in  1  clock
//   iReset  in  1  asynchronous active-low reset
//   bus     slave modport of nfc_rx_byte_packer_if (FIFO pop side + DMA word side)
module nfc_rx_byte_packer
    import nfc_rx_pkg::*;
    #(parameter int COUNT_WIDTH = 16) (
    input  logic                   iClock,
    input  logic                   iReset,
    nfc_rx_byte_packer_if.slave    bus
);

    logic                   rPending;
    logic                   rHalf;
    logic [15:0]            rLo;
    logic [31:0]            rData;
    logic [3:0]             rKeep;
    logic                   rLast;
    logic                   rValid;
    logic                   rClear;
    logic [COUNT_WIDTH-1:0] rCount;

    fifoEntryT e0;
    fifoEntryT e1;
    assign e0 = bus.iFifoData[HALF_W-1:ENTRY_W];
    assign e1 = bus.iFifoData[ENTRY_W-1:0];

    logic accept;
    logic stalled;
    assign accept  = rValid && bus.iReady;
    assign stalled = rValid && !bus.iReady;

    // Gating with iReset keeps the strobe low while reset is asserted.
    // Blocking on rPending limits pops to one per two clocks, which also
    // guarantees the output stage is empty on every capture cycle.
    assign bus.oFifoPop = iReset && !bus.iFifoEmpty && !rPending && !stalled;

    logic        emit;
    logic [31:0] nData;
    logic [3:0]  nKeep;
    logic        nLast;

    always_comb begin
        emit  = 1'b0;
        nData = 32'h0;
        nKeep = 4'h0;
        nLast = 1'b0;
        if (rHalf) begin
            emit = 1'b1;
            if (e0.bLast) begin
                nData = {8'h00, e0.data, rLo};
                nKeep = KEEP_3B;
                nLast = 1'b1;
            end else begin
                nData = {e1.data, e0.data, rLo};
                nKeep = KEEP_4B;
                nLast = e1.bLast;
            end
        end else if (e0.bLast) begin
            emit  = 1'b1;
            nData = {24'h0, e0.data};
            nKeep = KEEP_1B;
            nLast = 1'b1;
        end else if (e1.bLast) begin
            emit  = 1'b1;
            nData = {16'h0, e1.data, e0.data};
            nKeep = KEEP_2B;
            nLast = 1'b1;
        end
    end

    logic [COUNT_WIDTH-1:0] addend;
    assign addend = COUNT_WIDTH'(keepBytes(rKeep));

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            rPending <= 1'b0;
            rHalf    <= 1'b0;
            rLo      <= 16'h0;
            rData    <= 32'h0;
            rKeep    <= 4'h0;
            rLast    <= 1'b0;
            rValid   <= 1'b0;
            rClear   <= 1'b0;
            rCount   <= '0;
        end else begin
            rPending <= bus.oFifoPop;

            if (rPending) begin
                // Any emit ends the half-word; a non-emitting capture can only
                // happen from rHalf=0 and parks the two bytes in rLo.
                rHalf <= !emit;
                if (!emit) begin
                    rLo <= {e1.data, e0.data};
                end
            end

            if (rPending && emit) begin
                rData  <= nData;
                rKeep  <= nKeep;
                rLast  <= nLast;
                rValid <= 1'b1;
            end else if (accept) begin
                rValid <= 1'b0;
            end

            // The final total stays visible for one cycle before clearing.
            rClear <= accept && rLast;
            if (accept) begin
                rCount <= (rClear ? '0 : rCount) + addend;
            end else if (rClear) begin
                rCount <= '0;
            end
        end
    end

    assign bus.oData      = rData;
    assign bus.oKeep      = rKeep;
    assign bus.oLast      = rLast;
    assign bus.oValid     = rValid;
    assign bus.oByteCount = rCount;

endmodule

// File: tb/tb_nfc_rx_byte_packer.sv
// tb/tb_nfc_rx_byte_packer.sv - scoreboard bench for nfc_rx_byte_packer
module tb_nfc_rx_byte_packer;
    import nfc_rx_pkg::*;

    logic clk = 1'b0;
    logic rstN;

    nfc_rx_byte_packer_if #(.COUNT_WIDTH(16)) bus();

    nfc_rx_byte_packer #(.COUNT_WIDTH(16)) dut (
        .iClock (clk),
        .iReset (rstN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Standard-read FIFO model: data appears the cycle after the pop.
    logic [17:0] fifoMem [0:4095];
    int          wrPtr = 0;
    int          rdPtr = 0;
    logic [17:0] fifoDout = '0;

    assign bus.iFifoData  = fifoDout;
    assign bus.iFifoEmpty = (wrPtr == rdPtr);

    always @(posedge clk) begin
        if (bus.oFifoPop && (rdPtr != wrPtr)) begin
            fifoDout <= fifoMem[rdPtr];
            rdPtr    <= rdPtr + 1;
        end
    end

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } expT;
    expT expQ[$];

    // Reference: a transfer of n bytes becomes ceil(n/4) words, lanes filled
    // in order from lane 0, last word flagged; odd transfers get one pad entry.
    task automatic pushTransfer(input logic [7:0] bytes[$]);
        int n;
        logic [8:0] ent[$];
        n = bytes.size();
        for (int i = 0; i < n; i++) ent.push_back({(i == n - 1), bytes[i]});
        if (n % 2 == 1) ent.push_back({1'($urandom_range(0, 1)), 8'hFF});
        for (int i = 0; i < ent.size(); i += 2) begin
            fifoMem[wrPtr] = {ent[i], ent[i+1]};
            wrPtr++;
        end
        for (int i = 0; i < n; i += 4) begin
            expT e;
            e.data = '0;
            e.keep = '0;
            for (int j = 0; j < 4; j++) begin
                if (i + j < n) begin
                    e.data[8*j +: 8] = bytes[i+j];
                    e.keep[j] = 1'b1;
                end
            end
            e.last = (i + 4 >= n);
            expQ.push_back(e);
        end
    endtask

    // Monitor / scoreboard
    int          cyc = 0;
    int          clrStage = 0;
    logic [15:0] runBytes = '0;
    logic [15:0] lastTotal = '0;
    logic        prevPop = 1'b0;
    logic        prevValid = 1'b0;
    logic        logOn = 1'b0;
    int          popCyc[$];
    int          vldCyc[$];

    always @(negedge clk) begin
        cyc++;
        if (!rstN) begin
            runBytes  = '0;
            clrStage  = 0;
            prevPop   = 1'b0;
            prevValid = 1'b0;
        end else begin
            if (bus.oFifoPop) check("pop_cadence", {31'b0, prevPop}, 32'h0);
            if (logOn && bus.oFifoPop) popCyc.push_back(cyc);
            if (logOn && bus.oValid && !prevValid) vldCyc.push_back(cyc);
            prevPop   = bus.oFifoPop;
            prevValid = bus.oValid;

            if (clrStage == 1) begin
                check("count_total", {16'h0, bus.oByteCount}, {16'h0, lastTotal});
                clrStage = 2;
            end else if (clrStage == 2) begin
                check("count_clear", {16'h0, bus.oByteCount}, 32'h0);
                clrStage = 0;
            end

            if (bus.oValid && bus.iReady) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("FAIL unexpected_word: got 0x%0h keep 0x%0h, expected no word", bus.oData, bus.oKeep);
                end else begin
                    expT e;
                    e = expQ.pop_front();
                    check("word_data", bus.oData, e.data);
                    check("word_keep", {28'h0, bus.oKeep}, {28'h0, e.keep});
                    check("word_last", {31'h0, bus.oLast}, {31'h0, e.last});
                    check("byte_count", {16'h0, bus.oByteCount}, {16'h0, runBytes});
                    runBytes = runBytes + 16'($countones(e.keep));
                    if (e.last) begin
                        lastTotal = runBytes;
                        runBytes  = '0;
                        clrStage  = 1;
                    end
                end
            end
        end
    end

    task automatic waitDrain(input string name, input bit randReady, input int budget);
        int c;
        c = 0;
        while (c < budget && (expQ.size() != 0 || !bus.iFifoEmpty)) begin
            @(posedge clk);
            #1;
            if (randReady) bus.iReady = ($urandom_range(0, 3) != 0);
            c++;
        end
        bus.iReady = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check({"drain_", name}, expQ.size(), 32'h0);
    endtask

    task automatic checkResetOutputs(input string name);
        check({name, "_valid"}, {31'h0, bus.oValid}, 32'h0);
        check({name, "_data"},  bus.oData, 32'h0);
        check({name, "_keep"},  {28'h0, bus.oKeep}, 32'h0);
        check({name, "_last"},  {31'h0, bus.oLast}, 32'h0);
        check({name, "_pop"},   {31'h0, bus.oFifoPop}, 32'h0);
        check({name, "_count"}, {16'h0, bus.oByteCount}, 32'h0);
    endtask

    initial begin
        logic [7:0] b[$];
        logic [31:0] held;
        bit found;

        rstN       = 1'b0;
        bus.iReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rstN       = 1'b1;
        bus.iReady = 1'b1;
        @(posedge clk);
        #1;

        // 1: two full words, count 4 -> 8 -> 0
        b = {};
        for (int i = 1; i <= 8; i++) b.push_back(8'(i));
        pushTransfer(b);
        waitDrain("t1", 1'b0, 200);

        // 2: three bytes plus pad
        b = {8'hA0, 8'hA1, 8'hA2};
        pushTransfer(b);
        waitDrain("t2", 1'b0, 200);

        // 3: single byte, then word-aligned restart
        b = {8'h55};
        pushTransfer(b);
        b = {8'h10, 8'h11, 8'h12, 8'h13};
        pushTransfer(b);
        waitDrain("t3", 1'b0, 200);

        // 4: 64 bytes with a 10-cycle stall mid-stream
        b = {};
        for (int i = 0; i < 64; i++) b.push_back(8'(8'h40 + i));
        pushTransfer(b);
        repeat (20) @(posedge clk);
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(posedge clk);
            #1;
            if (bus.oValid) found = 1'b1;
        end
        check("stall_found_word", {31'h0, found}, 32'h1);
        bus.iReady = 1'b0;
        held = bus.oData;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_no_pop", {31'h0, bus.oFifoPop}, 32'h0);
            check("stall_hold", bus.oData, held);
        end
        @(posedge clk);
        #1;
        bus.iReady = 1'b1;
        waitDrain("t4", 1'b0, 400);

        // 5: continuous FIFO, pop every other cycle, 1 word per 4 clk
        popCyc.delete();
        vldCyc.delete();
        b = {};
        for (int i = 0; i < 32; i++) b.push_back(8'($urandom));
        logOn = 1'b1;
        pushTransfer(b);
        waitDrain("t5", 1'b0, 300);
        logOn = 1'b0;
        check("t5_pops", popCyc.size(), 32'd16);
        check("t5_words", vldCyc.size(), 32'd8);
        for (int i = 1; i < popCyc.size(); i++)
            check("t5_pop_spacing", popCyc[i] - popCyc[i-1], 32'd2);
        if (popCyc.size() > 1 && vldCyc.size() > 0)
            check("t5_first_valid", vldCyc[0] - popCyc[1], 32'd2);
        for (int i = 1; i < vldCyc.size(); i++)
            check("t5_word_spacing", vldCyc[i] - vldCyc[i-1], 32'd4);

        // 6: reset while two bytes are held, then a fresh aligned transfer
        for (int i = 0; i < 3; i++) begin
            fifoMem[wrPtr] = {1'b0, 8'(8'hC0 + 2*i), 1'b0, 8'(8'hC1 + 2*i)};
            wrPtr++;
        end
        expQ.push_back('{data: 32'hC3C2C1C0, keep: 4'hF, last: 1'b0});
        repeat (20) @(posedge clk);
        #1;
        check("t6_pre_reset_drained", expQ.size(), 32'h0);
        rstN = 1'b0;
        #1;
        checkResetOutputs("midreset");
        expQ.delete();
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        b = {8'h10, 8'h11, 8'h12, 8'h13};
        pushTransfer(b);
        waitDrain("t6", 1'b0, 200);

        // 7: random transfers with random backpressure
        for (int t = 0; t < 12; t++) begin
            for (int k = 0; k < 2; k++) begin
                int n;
                n = $urandom_range(1, 19);
                b = {};
                for (int i = 0; i < n; i++) b.push_back(8'($urandom));
                pushTransfer(b);
            end
            waitDrain("t7", 1'b1, 600);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
